// File: rtl/seq_gen_pkg.sv
// seq_generator shared types: FSM encoding and default widths.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int PAT_W_DEF   = 4;
    localparam int GAP_LEN_DEF = 3;
    localparam int REP_W       = 4;

endpackage

// File: rtl/seq_gen_if.sv
// Request/stream bundle between a pattern source and seq_generator.
interface seq_gen_if
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
);

    logic             start;
    logic [PAT_W-1:0] pat_in;
    logic [REP_W-1:0] reps;
    logic             seq_out;
    logic             seq_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pat_in, reps,
        input  seq_out, seq_valid, busy, done
    );

    modport slave (
        input  start, pat_in, reps,
        output seq_out, seq_valid, busy, done
    );

endinterface

// File: rtl/seq_piso.sv
// Parallel-in/serial-out shifter with a held pattern copy for repeats.
module seq_piso #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic         reload,
    input  logic [W-1:0] pat,
    output logic         msb_n
);

    logic [W-1:0] shreg;
    logic [W-1:0] shreg_n;
    logic [W-1:0] pat_q;

    always_comb begin
        shreg_n = shreg;
        unique case (1'b1)
            load:    shreg_n = pat;
            reload:  shreg_n = pat_q;
            shift:   shreg_n = {shreg[W-2:0], 1'b0};
            default: shreg_n = shreg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            pat_q <= '0;
        end else begin
            shreg <= shreg_n;
            if (load) pat_q <= pat;
        end
    end

    // Next-cycle MSB lets the top register seq_out without a cycle of lag.
    assign msb_n = shreg_n[W-1];

endmodule

// File: rtl/seq_generator.sv
// Serial pattern transmitter, MSB first, R+1 repetitions.
// Define SEQ_GEN_GAP_EN to insert GAP_LEN idle cycles between repetitions.
module seq_generator
    import seq_gen_pkg::*;
#(
    parameter int PAT_W   = PAT_W_DEF,
    parameter int GAP_LEN = GAP_LEN_DEF
) (
    input logic     clk,
    input logic     reset,
    seq_gen_if.slave bus
);

    localparam int CNT_W = $clog2(PAT_W);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(PAT_W - 1);

    if (PAT_W < 2 || GAP_LEN < 1) begin : g_bad_param
        $error("seq_generator: PAT_W must be >= 2 and GAP_LEN >= 1");
    end

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_n;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_cnt_n;
    logic             load;
    logic             shift;
    logic             reload;
    logic             msb_n;
    logic             seq_out_n;
    logic             seq_valid_n;
    logic             busy_n;
    logic             done_n;

`ifdef SEQ_GEN_GAP_EN
    localparam int GAP_W = $clog2(GAP_LEN + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);

    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_cnt_n;
`endif

    seq_piso #(
        .W (PAT_W)
    ) u_piso (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .shift  (shift),
        .reload (reload),
        .pat    (bus.pat_in),
        .msb_n  (msb_n)
    );

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        rep_cnt_n = rep_cnt;
        load      = 1'b0;
        shift     = 1'b0;
        reload    = 1'b0;
`ifdef SEQ_GEN_GAP_EN
        gap_cnt_n = gap_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    rep_cnt_n = bus.reps;
                    bit_cnt_n = '0;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == BIT_LAST) begin
                    if (rep_cnt != '0) begin
                        rep_cnt_n = rep_cnt - 1'b1;
                        reload    = 1'b1;
                        bit_cnt_n = '0;
`ifdef SEQ_GEN_GAP_EN
                        gap_cnt_n = '0;
                        state_n   = GAP;
`else
                        state_n   = SHIFT;
`endif
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    shift     = 1'b1;
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
`ifdef SEQ_GEN_GAP_EN
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_n = '0;
                    state_n   = SHIFT;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from next state so they land in registers.
    always_comb begin
        seq_valid_n = (state_n == SHIFT);
        seq_out_n   = seq_valid_n & msb_n;
        busy_n      = (state_n != IDLE);
        done_n      = (state_n == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            rep_cnt       <= '0;
            bus.seq_out   <= 1'b0;
            bus.seq_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            state         <= state_n;
            bit_cnt       <= bit_cnt_n;
            rep_cnt       <= rep_cnt_n;
            bus.seq_out   <= seq_out_n;
            bus.seq_valid <= seq_valid_n;
            bus.busy      <= busy_n;
            bus.done      <= done_n;
        end
    end

`ifdef SEQ_GEN_GAP_EN
    always_ff @(posedge clk) begin
        if (reset) gap_cnt <= '0;
        else       gap_cnt <= gap_cnt_n;
    end
`endif

endmodule

// File: doc/seq_generator.md
# seq_generator

Serial pattern transmitter: loads a PAT_W-bit pattern on a start pulse and shifts it out MSB-first, one bit per clock, repeated a programmable number of times. It is the transmit-side counterpart of the serial sequence detectors in this design. It drives detector inputs with known bit streams, both overlapping (back-to-back repetitions) and gapped.

## Interface
- PAT_W, 4: pattern width in bits, at least 2.
- GAP_LEN, 3: number of idle cycles between repetitions. Used only when the gap feature is compiled in. At least 1.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- start  in  1  request pulse. Sampled only in IDLE.
- pat_in  in  PAT_W  pattern. Captured on the accepting edge.
- reps  in  4  repetition count R, giving R+1 transmissions. Captured on the accepting edge.
- seq_out  out  1  serial data, pattern MSB first.
- seq_valid  out  1  high in every cycle that carries a pattern bit.
- busy  out  1  high from the accepting edge until done is deasserted.
- done  out  1  one-cycle completion pulse.

## Operation
- All outputs are registered (Moore). Reset value of every output is 0. The state after reset is IDLE.
- States: IDLE, SHIFT, GAP (present only with the gap feature), DONE.
- IDLE:
  - start=1 captures pat_in into the shift register, reps into rep_cnt, and clears bit_cnt.
  - Next state is SHIFT.
  - start=0 keeps the FSM in IDLE with all outputs 0.
- SHIFT:
  - seq_out = shreg[PAT_W-1], seq_valid=1, busy=1.
  - Each edge shifts left by one bit and increments bit_cnt.
  - After bit PAT_W-1:
    - If rep_cnt≠0, decrement rep_cnt, reload shreg from the captured pattern copy, clear bit_cnt, and go to GAP (gap build) or stay in SHIFT (no-gap build).
    - If rep_cnt=0, go to DONE.
- GAP:
  - seq_out=0, seq_valid=0, busy=1 for exactly GAP_LEN cycles, then return to SHIFT.
- DONE:
  - done=1, busy=1, seq_valid=0 for one cycle, then IDLE.
- start is ignored in SHIFT, GAP and DONE. It is never queued.
- pat_in and reps may change freely after capture without affecting the transfer in progress.
- Width rules:
  - bit_cnt is $clog2(PAT_W) bits and wraps only under FSM control.
  - rep_cnt is 4 bits and never underflows. The decrement happens only when rep_cnt≠0.
  - The gap counter is $clog2(GAP_LEN+1) bits.
- Reset mid-operation: at the next edge all outputs go to 0, the state goes to IDLE, and the counters clear. There is no partial pattern or done pulse.
- reset and start asserted together: reset wins.

## Timing
- Let E be the edge that accepts start.
- Bit k is presented in cycle E+1+k, for k=0..PAT_W-1.
- Repetition r, counted from 0, starts at E+1+r·(PAT_W+G), where G is GAP_LEN in the gap build and 0 otherwise.
- done is high in the cycle after the final bit. Total busy length is (R+1)·PAT_W + R·G + 1 cycles.
- The earliest accepted restart is the edge ending the first IDLE cycle after DONE.

## Configuration
- SEQ_GEN_GAP_EN defined:
  - The GAP state and gap counter exist.
  - Repetitions are separated by GAP_LEN cycles with seq_out=0 and seq_valid=0.
- SEQ_GEN_GAP_EN undefined:
  - No GAP state and no gap counter.
  - Repetitions are emitted back-to-back, so seq_valid stays high for (R+1)·PAT_W consecutive cycles.
  - This exercises overlapping-match behaviour in downstream detectors.

## Structure
- Package seq_gen_pkg holds:
  - State encodings: IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, DONE=2'b11.
  - Default PAT_W, GAP_LEN, and the rep-counter width of 4.
- One sub-module, seq_piso: a PAT_W-bit parallel-in/serial-out shift register with load, shift and pattern-reload controls. The FSM and counters stay in seq_generator.

## Test plan
- Reset, then start at E with pat_in=4'b1011, reps=0:
  - seq_out = 1,0,1,1 in cycles E+1..E+4 with seq_valid=1.
  - done=1 at E+5.
  - busy low at E+6.
- No-gap build, pat_in=4'b1011, reps=2:
  - seq_valid high for 12 consecutive cycles, stream 101110111011.
  - A downstream overlapping 1011 detector fires exactly 3 times.
- Gap build, GAP_LEN=3, pat_in=4'b1011, reps=1:
  - Cycles E+1..E+4 carry 1011, E+5..E+7 have seq_valid=0 and seq_out=0, E+8..E+11 carry 1011.
  - done at E+12.
- start pulsed at E+2 during an active transfer:
  - No effect; the output stream is identical to the single-start case.
  - pat_in changed at E+1 has no effect either.
- reset asserted at edge E+3 mid-pattern:
  - From E+3, seq_out, seq_valid, busy and done are all 0.
  - No done pulse; a new start at E+5 transmits a full pattern normally.
- reps=4'hF, pat_in=4'b0001:
  - 16 repetitions, done after the last bit.
  - rep_cnt never wraps, checked by an assertion on the busy length formula.
